xlib_xyz_fifos_prog: RTL

Parametrised single-clock FIFO, the next generation of the xlib FIFO wrapper family. Vendor-neutral inferred-RAM implementation: FWFT/show-ahead or normal read mode selectable per instance, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and synchronous flush. Used inside single-clock datapaths (SPI byte buffering, command queues) where a dual-clock FIFO is unnecessary.

---
 rtl/xlib_xyz_fifos_prog_pkg.sv | 15 +
 rtl/xlib_xyz_sdpram.sv | 49 ++++
 rtl/xlib_xyz_fifos_prog.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/xlib_xyz_fifos_prog_pkg.sv
// Shared definitions for the xlib_xyz_fifos_prog FIFO family.
//   ptr_w()      : pointer width for a given address width. The extra MSB
//                  tells a full FIFO apart from an empty one.
//   MODE_FWFT    : read port shows the head word whenever rne=1.
//   MODE_NORMAL  : read data is valid one cycle after an accepted read.
package xlib_xyz_fifos_prog_pkg;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_FWFT   = 1;

    function automatic int ptr_w(input int fw);
        return fw + 1;
    endfunction

endpackage

// File: rtl/xlib_xyz_sdpram.sv
// Simple dual-port RAM, DW x 2**AW words. It has one write port and one
// registered read port with a read enable. The read data register is
// cleared by rst so that the FIFO read bus starts at zero. The array
// itself is not cleared.
//   clk : clock               rst : async active-high, read register only
//   we  : write enable        wa  : write address     wd : write data
//   re  : read enable         ra  : read address      rd : registered read data
module xlib_xyz_sdpram
    import xlib_xyz_fifos_prog_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;

    // NOTE: the array has no reset. Adding one would stop the tools from
    // mapping it onto block RAM. The FIFO never reads a word it has not
    // written, so the array contents after reset do not matter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // NOTE: use non-blocking assignments for clocked state. All flops then
    // sample their inputs from before the edge, whatever order they
    // update in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[ra];
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/xlib_xyz_fifos_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
//   clk, rst       : clock, async active-high reset
//   flush          : synchronous empty; wreq/rreq ignored that cycle
//   wreq, wd, wnf  : write request, write data, not-full
//   rreq, rd, rne  : read request, read data, not-empty
//   cnt            : words held, including the FWFT output stage
//   af_th, ae_th   : thresholds; afull = cnt >= af_th, aempty = cnt <= ae_th
//   ovf, udf       : sticky write-when-full / read-when-empty
//   clr_err        : clears ovf/udf; a new error in the same cycle wins
// FWFT=1 uses the RAM read register as the output stage, and cnt includes
// it. FWFT=0 gives read data in a separate register one cycle after the
// RAM read.
module xlib_xyz_fifos_prog
    import xlib_xyz_fifos_prog_pkg::*;
#(
    parameter int DW   = 32,
    parameter int FW   = 8,
    parameter int FWFT = MODE_FWFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wreq,
    input  logic [DW-1:0]        wd,
    output logic                 wnf,
    input  logic                 rreq,
    output logic [DW-1:0]        rd,
    output logic                 rne,
    output logic [ptr_w(FW)-1:0] cnt,
    input  logic [ptr_w(FW)-1:0] af_th,
    input  logic [ptr_w(FW)-1:0] ae_th,
    output logic                 afull,
    output logic                 aempty,
    output logic                 ovf,
    output logic                 udf,
    input  logic                 clr_err
);

    localparam int PW = ptr_w(FW);
    localparam logic [PW-1:0] DEPTH   = {1'b1, {FW{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE = {{FW{1'b0}}, 1'b1};

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          wnf_q, wnf_d;
    logic          rne_q, rne_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic          ram_re;
    logic [DW-1:0] ram_rd;

    // NOTE: give every always_comb output a default before any branch.
    // A path that leaves an output unassigned would infer a latch.
    always_comb begin
        wr_acc = wreq & wnf_q & ~flush;
        rd_acc = rreq & rne_q & ~flush;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + PTR_ONE;
                2'b01:   cnt_d = cnt_q - PTR_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
        // Flags are taken from the next count, so they change on the same
        // edge as cnt.
        wnf_d    = (cnt_d != DEPTH);
        afull_d  = (cnt_d >= af_th);
        aempty_d = (cnt_d <= ae_th);
        // Error flags: clr_err clears them, and a new error in the same
        // cycle takes priority. Requests in a flush cycle never set them.
        ovf_d = clr_err ? 1'b0 : ovf_q;
        udf_d = clr_err ? 1'b0 : udf_q;
        if (!flush && wreq && !wnf_q) begin
            ovf_d = 1'b1;
        end
        if (!flush && rreq && !rne_q) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            wnf_q    <= 1'b1;
            rne_q    <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            wnf_q    <= wnf_d;
            rne_q    <= rne_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    if (FWFT == MODE_NORMAL) begin : g_normal
        // A read is accepted at edge j, the RAM reads at edge j, and the
        // word moves into rd_q at edge j+1. rd_q then holds until the next
        // read.
        logic          pend_q, pend_d;
        logic [DW-1:0] rd_q, rd_d;

        always_comb begin
            ram_re = rd_acc;
            rptr_d = flush ? '0 : (rd_acc ? rptr_q + PTR_ONE : rptr_q);
            rne_d  = (cnt_d != '0);
            pend_d = rd_acc;
            rd_d   = pend_q ? ram_rd : rd_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q <= 1'b0;
                rd_q   <= '0;
            end else begin
                pend_q <= pend_d;
                rd_q   <= rd_d;
            end
        end

        assign rd = rd_q;
    end else begin : g_fwft
        // The RAM read register is the output stage, and rne_q marks it as
        // valid. rptr_q points at the next word to fetch. Words still in
        // the array number cnt minus the staged word. The stage refills
        // whenever it is empty or being read and the array has a word.
        // A word written at edge k is in the array in time for a fetch at
        // edge k+1.
        logic [PW-1:0] ram_words;

        always_comb begin
            ram_words = cnt_q - (rne_q ? PTR_ONE : '0);
            ram_re    = ~flush & (~rne_q | rd_acc) & (ram_words != '0);
            rptr_d    = flush ? '0 : (ram_re ? rptr_q + PTR_ONE : rptr_q);
            rne_d     = ~flush & (ram_re | (rne_q & ~rd_acc));
        end

        assign rd = ram_rd;
    end

    xlib_xyz_sdpram #(
        .DW (DW),
        .AW (FW)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (wr_acc),
        .wa  (wptr_q[FW-1:0]),
        .wd  (wd),
        .re  (ram_re),
        .ra  (rptr_q[FW-1:0]),
        .rd  (ram_rd)
    );

    assign wnf    = wnf_q;
    assign rne    = rne_q;
    assign cnt    = cnt_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
